// File: rtl/bus_arb.sv
// Round-robin arbiter for a shared address/data bus: one owner at a time,
// a hold limit that only bites under contention, and a one-cycle turnaround.
module bus_arb #(
  parameter int N_REQ     = 2,
  parameter int AD_LEN    = 32,
  parameter int BUS_WIDTH = 32,
  parameter int MAX_HOLD  = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ*AD_LEN-1:0] ad_i,
  input  logic [BUS_WIDTH-1:0]    bus_data_i,
  output logic [AD_LEN-1:0]       bus_ad_o,
  output logic [N_REQ-1:0]        gnt_o,
  output logic [BUS_WIDTH-1:0]    data_o,
  output logic [N_REQ-1:0]        data_valid_o
);

  localparam int PTR_W  = $clog2(N_REQ);
  localparam int HOLD_W = $clog2(MAX_HOLD);
  localparam logic [PTR_W-1:0]  LAST_IDX   = PTR_W'(N_REQ - 1);
  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD - 1);
  localparam logic [N_REQ-1:0]  ONE_HOT0   = N_REQ'(1);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  state_t            state;
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  owner;
  logic [HOLD_W-1:0] hold_cnt;

  logic [PTR_W-1:0]  pick_idx;
  logic              pick_valid;
  logic [PTR_W-1:0]  next_ptr;
  logic [N_REQ-1:0]  owner_mask;
  logic              owner_req;
  logic              other_req;
  logic              hold_expired;
  int                cand;

  // Scan downward so the last hit is the first requester at or after rr_ptr.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = int'(rr_ptr) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (req_i[cand[PTR_W-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[PTR_W-1:0];
      end
    end
  end

  assign owner_mask   = ONE_HOT0 << owner;
  assign owner_req    = |(req_i & owner_mask);
  assign other_req    = |(req_i & ~owner_mask);
  assign hold_expired = (hold_cnt == HOLD_LIMIT);
  assign next_ptr     = (owner == LAST_IDX) ? '0 : owner + 1'b1;

  // The owner's address passes straight through so address changes land on the bus in-cycle.
  assign bus_ad_o = (state == GRANT) ? ad_i[owner*AD_LEN +: AD_LEN] : '0;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      owner        <= '0;
      hold_cnt     <= '0;
      gnt_o        <= '0;
      data_o       <= '0;
      data_valid_o <= '0;
    end else begin
      data_valid_o <= '0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner    <= pick_idx;
            hold_cnt <= '0;
            gnt_o    <= ONE_HOT0 << pick_idx;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (!hold_expired) hold_cnt <= hold_cnt + 1'b1;
          if (!owner_req) begin
            state  <= TURN;
            gnt_o  <= '0;
            rr_ptr <= next_ptr;
          end else begin
            data_o       <= bus_data_i;
            data_valid_o <= owner_mask;
            // The last transfer of a forced release still completes.
            if (hold_expired && other_req) begin
              state  <= TURN;
              gnt_o  <= '0;
              rr_ptr <= next_ptr;
            end
          end
        end
        TURN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          gnt_o <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arb.sv
// Randomized and directed bench for bus_arb with four requesters, checked
// against a tenure/cooldown model of the arbitration rules.
module tb_bus_arb;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MH = 8;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req_v;
  logic [N*AW-1:0] ad_v;
  logic [DW-1:0]   data_v;
  logic [AW-1:0]   bus_ad;
  logic [N-1:0]    gnt;
  logic [DW-1:0]   data_out;
  logic [N-1:0]    data_valid;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: who owns the bus, how many cycles it has held it,
  // how many dead cycles remain before the next arbitration, and where the
  // round-robin search starts.
  int            m_owner;
  int            m_tenure;
  int            m_cool;
  int            m_ptr;
  logic [DW-1:0] exp_data;
  logic [N-1:0]  exp_dv;

  bus_arb #(.N_REQ(N), .AD_LEN(AW), .BUS_WIDTH(DW), .MAX_HOLD(MH)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .req_i        (req_v),
    .ad_i         (ad_v),
    .bus_data_i   (data_v),
    .bus_ad_o     (bus_ad),
    .gnt_o        (gnt),
    .data_o       (data_out),
    .data_valid_o (data_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] expGnt();
    return (m_owner >= 0) ? N'(1) << m_owner : '0;
  endfunction

  function automatic logic [AW-1:0] expAd();
    return (m_owner >= 0) ? AW'(ad_v >> (m_owner * AW)) : '0;
  endfunction

  task automatic modelReset();
    m_owner  = -1;
    m_tenure = 0;
    m_cool   = 0;
    m_ptr    = 0;
    exp_data = '0;
    exp_dv   = '0;
  endtask

  task automatic releaseBus();
    m_ptr   = (m_owner + 1) % N;
    m_owner = -1;
    m_cool  = 1;
  endtask

  // One rising edge of the specified behaviour, using the inputs present at that edge.
  task automatic modelEdge();
    logic [N-1:0] om;
    exp_dv = '0;
    if (m_owner >= 0) begin
      om = N'(1) << m_owner;
      if ((req_v & om) != '0) begin
        exp_data = data_v;
        exp_dv   = om;
        m_tenure++;
        if (m_tenure >= MH && (req_v & ~om) != '0) releaseBus();
      end else begin
        releaseBus();
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else if (req_v != '0) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (m_owner < 0 && (req_v & (N'(1) << idx)) != '0) m_owner = idx;
      end
      m_tenure = 0;
    end
  endtask

  // Called at a falling edge: drive inputs, check the combinational address,
  // step the model across the rising edge, then check registered outputs.
  task automatic applyStimulus(input logic [N-1:0] r, input logic [N*AW-1:0] a, input logic [DW-1:0] d);
    req_v  = r;
    ad_v   = a;
    data_v = d;
    #1;
    checkOutput("bus_ad_comb", 64'(bus_ad), 64'(expAd()));
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkOutput("gnt", 64'(gnt), 64'(expGnt()));
    checkOutput("data_valid", 64'(data_valid), 64'(exp_dv));
    checkOutput("data", 64'(data_out), 64'(exp_data));
    checkOutput("bus_ad", 64'(bus_ad), 64'(expAd()));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_gnt"}, 64'(gnt), 64'(0));
    checkOutput({tag, "_bus_ad"}, 64'(bus_ad), 64'(0));
    checkOutput({tag, "_data_valid"}, 64'(data_valid), 64'(0));
    checkOutput({tag, "_data"}, 64'(data_out), 64'(0));
  endtask

  task automatic doReset();
    req_v = '0;
    reset = 1'b1;
    #1;
    checkAllZero("reset");
    modelReset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Reset pulsed between edges; must take effect without a clock edge.
  task automatic asyncPulse();
    reset = 1'b1;
    #1;
    checkAllZero("async_reset");
    modelReset();
    #1;
    reset = 1'b0;
  endtask

  function automatic logic [N*AW-1:0] randAd();
    logic [N*AW-1:0] v;
    for (int k = 0; k < N; k++) v[k*AW +: AW] = $urandom;
    return v;
  endfunction

  initial begin
    int pulses;
    int gcycles;
    logic [N*AW-1:0] ad_fix;
    logic [N-1:0] rnd_req;

    reset  = 1'b1;
    req_v  = '0;
    ad_v   = '0;
    data_v = '0;
    modelReset();
    repeat (2) @(negedge clk);
    checkAllZero("por");
    reset = 1'b0;

    // Two contenders from reset: 8-cycle tenure, 2-cycle gap, then requester 1.
    pulses  = 0;
    gcycles = 0;
    for (int c = 0; c < 11; c++) begin
      applyStimulus(4'b0011, randAd(), $urandom);
      if (data_valid[0]) pulses++;
      if (gnt == 4'b0001) gcycles++;
    end
    checkOutput("contend_pulses_r0", 64'(pulses), 64'(8));
    checkOutput("contend_cycles_r0", 64'(gcycles), 64'(8));
    checkOutput("contend_next_gnt", 64'(gnt), 64'(4'b0010));

    // A lone requester is never forced off.
    doReset();
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      applyStimulus(4'b0010, randAd(), $urandom);
      if (data_valid == 4'b0010) pulses++;
    end
    checkOutput("solo_pulses", 64'(pulses), 64'(19));
    checkOutput("solo_gnt_kept", 64'(gnt), 64'(4'b0010));

    // Owner drops its request after 3 transfers.
    doReset();
    pulses = 0;
    for (int c = 0; c < 7; c++) begin
      applyStimulus((c < 4) ? 4'b0011 : 4'b0010, randAd(), $urandom);
      if (data_valid[0]) pulses++;
      if (c == 4 || c == 5) checkOutput("drop_gap_gnt", 64'(gnt), 64'(0));
    end
    checkOutput("drop_pulses_r0", 64'(pulses), 64'(3));
    checkOutput("drop_next_gnt", 64'(gnt), 64'(4'b0010));

    // Address passthrough and registered read data.
    doReset();
    ad_fix = '0;
    ad_fix[AW-1:0] = 32'h0000_1000;
    applyStimulus(4'b0001, ad_fix, 32'h0);
    req_v  = 4'b0001;
    data_v = 32'hDEAD_BEEF;
    #1;
    checkOutput("xfer_bus_ad", 64'(bus_ad), 64'(32'h0000_1000));
    applyStimulus(4'b0001, ad_fix, 32'hDEAD_BEEF);
    checkOutput("xfer_data", 64'(data_out), 64'(32'hDEAD_BEEF));
    checkOutput("xfer_valid", 64'(data_valid), 64'(4'b0001));

    // Asynchronous reset mid-grant, then arbitration restarts from requester 0.
    doReset();
    applyStimulus(4'b0010, randAd(), $urandom);
    applyStimulus(4'b0010, randAd(), $urandom);
    asyncPulse();
    applyStimulus(4'b0011, randAd(), $urandom);
    checkOutput("after_reset_gnt", 64'(gnt), 64'(4'b0001));

    // Wrap-around search from pointer 3, then pointer moves to 1.
    doReset();
    applyStimulus(4'b0100, randAd(), $urandom);
    applyStimulus(4'b0100, randAd(), $urandom);
    applyStimulus(4'b0000, randAd(), $urandom);
    applyStimulus(4'b0011, randAd(), $urandom);
    applyStimulus(4'b0011, randAd(), $urandom);
    checkOutput("wrap_gnt", 64'(gnt), 64'(4'b0001));
    applyStimulus(4'b0000, randAd(), $urandom);
    applyStimulus(4'b0011, randAd(), $urandom);
    applyStimulus(4'b0011, randAd(), $urandom);
    checkOutput("wrap_ptr_next", 64'(gnt), 64'(4'b0010));

    // Random traffic: requests toggle occasionally so tenures build up.
    doReset();
    rnd_req = '0;
    for (int c = 0; c < 800; c++) begin
      for (int k = 0; k < N; k++)
        if ($urandom_range(0, 7) == 0) rnd_req[k] = ~rnd_req[k];
      if ($urandom_range(0, 99) == 0) asyncPulse();
      applyStimulus(rnd_req, randAd(), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arb.md
BUS_ARB -- requirements
Module: bus_arb

Interface
- REQ-001: Parameter N_REQ, default 2, is the number of requesters sharing the bus; legal range 2..8.
- REQ-002: Parameter AD_LEN, default 32, is the bus address width.
- REQ-003: Parameter BUS_WIDTH, default 32, is the bus data width.
- REQ-004: Parameter MAX_HOLD, default 8, is the maximum granted cycles before forced release when contended; legal range 2..255.
- REQ-005: clk_i  input  1  clock; every state element updates on its rising edge.
- REQ-006: reset_i  input  1  reset, asynchronous and active-high.
- REQ-007: req_i  input  N_REQ  per-requester bus request; bit k belongs to requester k.
- REQ-008: ad_i  input  N_REQ*AD_LEN  per-requester address; slice k is [k*AD_LEN +: AD_LEN].
- REQ-009: bus_data_i  input  BUS_WIDTH  read data returned by the bus in the same cycle as bus_ad_o.
- REQ-010: bus_ad_o  output  AD_LEN  address driven onto the shared bus.
- REQ-011: gnt_o  output  N_REQ  one-hot grant (all-zero when no owner).
- REQ-012: data_o  output  BUS_WIDTH  registered copy of bus_data_i.
- REQ-013: data_valid_o  output  N_REQ  one-hot, one-cycle pulse marking data_o as valid for that requester.

Function
- REQ-014: The state machine SHALL have the states IDLE, GRANT, and TURN.
- REQ-015: In IDLE with req_i nonzero, the block SHALL select the first asserted bit at or after rr_ptr (searching upward, wrapping modulo N_REQ), register the owner, and enter GRANT; gnt_o SHALL assert on the following cycle.
- REQ-016: In IDLE with req_i all zero, the block SHALL remain in IDLE.
- REQ-017: In GRANT, gnt_o SHALL be one-hot on the owner and bus_ad_o SHALL combinationally equal the owner's ad_i slice.
- REQ-018: Outside GRANT, gnt_o SHALL be 0 and bus_ad_o SHALL be 0.
- REQ-019: For every clock edge while in GRANT with req_i[owner]=1, data_o SHALL load bus_data_i and data_valid_o SHALL pulse on the owner bit during the next cycle; otherwise data_valid_o SHALL be 0 and data_o SHALL hold its value.
- REQ-020: hold_cnt SHALL clear on entry to GRANT and increment on each GRANT cycle, saturating at MAX_HOLD-1.
- REQ-021: In GRANT, if req_i[owner]=0, the block SHALL go to TURN; no data_valid_o pulse is generated for that cycle.
- REQ-022: In GRANT, if hold_cnt=MAX_HOLD-1 and any other req_i bit is set, the block SHALL go to TURN after this cycle's transfer, which still produces its data_valid_o pulse.
- REQ-023: In GRANT, if hold_cnt=MAX_HOLD-1 and no other requester is asserting, the block SHALL keep the grant.
- REQ-024: On leaving GRANT, rr_ptr SHALL be set to (owner+1) mod N_REQ.
- REQ-025: TURN SHALL last exactly one cycle, with gnt_o=0 (bus turnaround), and SHALL then go to IDLE; arbitration occurs in IDLE, so the handoff gap between owners is 2 cycles.
- REQ-026: Requests from requesters that are not the owner SHALL have no effect during GRANT except for the contention check in REQ-022.
- REQ-027: Changes to ad_i by the owner during GRANT SHALL pass through to bus_ad_o in the same cycle.

Reset
- REQ-028: While reset_i=1, the block SHALL be in state IDLE with rr_ptr=0, hold_cnt=0, owner=0, gnt_o=0, bus_ad_o=0, data_o=0, and data_valid_o=0, independent of clk_i.
- REQ-029: Reset asserted mid-GRANT SHALL immediately drop gnt_o and bus_ad_o and cancel any pending data_valid_o pulse.

Verification
- REQ-030: With N_REQ=2, req_i=2'b11 from reset release: gnt_o=01 one cycle later. Requester 0 holds for 8 cycles and gets 8 data_valid_o pulses. Then 2 cycles with gnt_o=00, then gnt_o=10.
- REQ-031: Only req_i[1]=1, held for 20 cycles: the grant to 1 persists and is never forced off; 19 consecutive data_valid_o=10 pulses follow grant assertion.
- REQ-032: Owner 0 drops req after 3 cycles while req_i[1]=1: TURN, IDLE, then gnt_o=10; data_valid_o for requester 0 pulses exactly 3 times.
- REQ-033: ad_i slice 0=0x0000_1000 and bus_data_i=0xDEAD_BEEF while gnt_o=01: bus_ad_o=0x0000_1000 in the same cycle; data_o=0xDEAD_BEEF and data_valid_o=01 in the next cycle.
- REQ-034: reset_i pulsed asynchronously (between edges) during GRANT: gnt_o, bus_ad_o, and data_valid_o go to 0 immediately. After release with req_i=11, the grant goes to requester 0 (rr_ptr=0).
- REQ-035: N_REQ=4, rr_ptr=3, req_i=4'b0011: the grant goes to requester 0 (search wraps around); after it is released, rr_ptr=1.
